if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register. It owns the program counter, drives a req/ack instruction-memory port, and applies stall, redirect (branch/jump) and flush. Its outputs update on the rising clock edge, so they are stable for the IF/ID register's falling-edge capture.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble instruction driven on flush or empty cycles.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  downstream hazard stall; outputs must hold
redirect  input  1  branch/jump taken; load redirect_pc and flush
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0
imem_req  output  1  instruction-memory request
imem_addr  output  32  word-aligned fetch address
imem_ack  input  1  memory response valid; may arrive in the request cycle or later
imem_rdata  input  32  instruction word, valid with imem_ack
pc_out  output  32  PC+4 of the delivered instruction
instr_out  output  32  delivered instruction
instr_valid  output  1  instr_out is a real instruction, not a bubble

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=ISSUE, pc_out=0, instr_out=NOP_INSTR, instr_valid=0, hold buffer=0. imem_req=0 while reset is high. First request goes out in the first cycle after reset deasserts.
- Memory handshake: once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack=1. Completion is sampled at the rising edge where imem_req && imem_ack.
- Internal registers: pc (next fetch address), req_addr (address of the outstanding request), hold_buf (32b).
- FSM states:
  - ISSUE: imem_req=1, imem_addr=req_addr. req_addr is loaded from pc when entering ISSUE.
    - ack && !redirect && !stall: instr_out<=imem_rdata, pc_out<=req_addr+4, instr_valid<=1, pc<=req_addr+4. Stay in ISSUE and issue the next request the following cycle.
    - ack && stall && !redirect: hold_buf<=imem_rdata, pc<=req_addr+4, go to HOLD. Outputs unchanged.
    - no ack, !stall, !redirect: instr_out<=NOP_INSTR, instr_valid<=0 (bubble). pc_out unchanged.
    - no ack, stall: outputs unchanged.
  - HOLD: imem_req=0.
    - !stall: instr_out<=hold_buf, pc_out<=pc, instr_valid<=1, go to ISSUE.
    - stall: remain in HOLD.
  - DROP: a redirect arrived while a request was outstanding. imem_req=1 with the old req_addr until ack. On ack, discard imem_rdata and go to ISSUE with the current pc.
- Redirect has priority over stall and ack in every state:
  - pc<=redirect_pc&~3, instr_out<=NOP_INSTR, instr_valid<=0, pc_out<=0.
  - From ISSUE with ack in the same cycle: discard data, go to ISSUE.
  - From ISSUE without ack: go to DROP.
  - From HOLD: discard hold_buf, go to ISSUE.
  - From DROP: update pc, stay in DROP.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. No misalignment exception; low bits are masked.
- Latency: with zero-wait memory (ack in the request cycle), one instruction per cycle. Rising edge N fetch produces valid outputs after edge N.
- Reset asserted mid-request: state forced to ISSUE and the response is ignored. The memory must tolerate an abandoned request.

Test Plan:
- Reset, then zero-wait memory returning 0x20080001, 0x20090002 at 0x0, 0x4 -> pc_out=0x4 then 0x8; instr_out matches; instr_valid=1 each cycle; imem_addr=0x0, 0x4, 0x8.
- Memory acks 2 cycles late at 0x0 -> imem_req/imem_addr held stable for 3 cycles; two bubble cycles (NOP, valid=0) delivered; then 0x20080001 with pc_out=0x4.
- stall asserted in the ack cycle for 3 cycles -> outputs frozen, imem_req=0 in HOLD; on release, buffered word delivered with pc_out=0x8 and fetch resumes at 0x8.
- redirect to 0x0000_0042 while a request at 0xC is outstanding -> outputs flush to NOP/valid=0/pc_out=0; 0xC response discarded; next request at 0x40.
- redirect and stall together in HOLD -> flush wins; next imem_addr=redirect_pc.
- pc=0xFFFF_FFFC fetched -> pc_out=0x0, next imem_addr=0x0. Reset pulsed mid-wait -> all outputs 0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the imem req/ack port,
// and feeds the PC/instruction pair into the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] hold_buf;
    logic [31:0] redir_al;
    logic [31:0] next_addr;

    assign redir_al  = redirect_pc & ~32'd3;
    assign next_addr = req_addr + 32'd4;

    // Request is live in ISSUE and DROP; suppressed while in reset.
    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = req_addr;

    // Fetch FSM: redirect first, then buffered word, then handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ISSUE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            hold_buf    <= 32'd0;
            pc_out      <= 32'd0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redir_al;
            pc_out      <= 32'd0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            unique case (state)
                HOLD: begin
                    req_addr <= redir_al;
                    state    <= ISSUE;
                end
                default: begin
                    // A completed handshake can be dropped right away;
                    // an open one must be seen through to its ack.
                    if (imem_ack) begin
                        req_addr <= redir_al;
                        state    <= ISSUE;
                    end else begin
                        state <= DROP;
                    end
                end
            endcase
        end else begin
            unique case (state)
                ISSUE: begin
                    if (imem_ack && !stall) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= next_addr;
                        instr_valid <= 1'b1;
                        pc          <= next_addr;
                        req_addr    <= next_addr;
                    end else if (imem_ack) begin
                        hold_buf <= imem_rdata;
                        pc       <= next_addr;
                        state    <= HOLD;
                    end else if (!stall) begin
                        instr_out   <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_out   <= hold_buf;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        req_addr    <= pc;
                        state       <= ISSUE;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        req_addr <= pc;
                        state    <= ISSUE;
                    end
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised + directed bench for if_fetch_unit against a
// transaction-level model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    int nchk = 0;
    int nerr = 0;

    if_fetch_unit #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .instr_out  (instr_out),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Model state: next fetch pc, address on the memory port,
    // whether a word is parked, whether the open fetch is stale.
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_parked;
    logic [31:0] m_word;
    logic        m_stale;
    logic [31:0] e_pc_out;
    logic [31:0] e_instr;
    logic        e_valid;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'h0)
            r = 32'h2008_0001;
        else if (a == 32'h4)
            r = 32'h2009_0002;
        else
            r = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        return r;
    endfunction

    task automatic model_reset();
        m_pc     = RPC;
        m_addr   = RPC;
        m_parked = 1'b0;
        m_word   = 32'd0;
        m_stale  = 1'b0;
        e_pc_out = 32'd0;
        e_instr  = NOP;
        e_valid  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, !m_parked});
        if (!m_parked)
            check({tag, "_addr"}, imem_addr, m_addr);
        check({tag, "_pc"}, pc_out, e_pc_out);
        check({tag, "_ins"}, instr_out, e_instr);
        check({tag, "_vld"}, {31'd0, instr_valid}, {31'd0, e_valid});
    endtask

    // One clock: apply inputs, advance model at the edge, check after.
    task automatic step(input logic s, input logic r,
                        input logic [31:0] rpc, input logic a);
        logic fire;
        logic [31:0] rd;
        fire        = a && !m_parked;
        rd          = memf(m_addr);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = fire;
        imem_rdata  = rd;
        @(posedge clk);
        if (r) begin
            e_pc_out = 32'd0;
            e_instr  = NOP;
            e_valid  = 1'b0;
            m_pc     = {rpc[31:2], 2'b00};
            if (m_parked || fire) begin
                m_parked = 1'b0;
                m_stale  = 1'b0;
                m_addr   = m_pc;
            end else begin
                m_stale = 1'b1;
            end
        end else if (m_parked) begin
            if (!s) begin
                e_instr  = m_word;
                e_pc_out = m_pc;
                e_valid  = 1'b1;
                m_parked = 1'b0;
                m_addr   = m_pc;
            end
        end else if (m_stale) begin
            if (fire) begin
                m_stale = 1'b0;
                m_addr  = m_pc;
            end
        end else if (fire) begin
            m_pc = m_addr + 32'd4;
            if (s) begin
                m_word   = rd;
                m_parked = 1'b1;
            end else begin
                e_instr  = rd;
                e_pc_out = m_pc;
                e_valid  = 1'b1;
                m_addr   = m_pc;
            end
        end else if (!s) begin
            e_instr = NOP;
            e_valid = 1'b0;
        end
        @(negedge clk);
        check_all("cyc");
    endtask

    // Reset pulse raised between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        imem_ack = 1'b0;
        #1;
        model_reset();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_ins", instr_out, NOP);
        check("rst_vld", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, RPC);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // zero-wait stream
        step(0, 0, 0, 1);
        check("zw_pc0", pc_out, 32'h4);
        check("zw_in0", instr_out, 32'h2008_0001);
        step(0, 0, 0, 1);
        check("zw_pc1", pc_out, 32'h8);
        check("zw_in1", instr_out, 32'h2009_0002);
        check("zw_addr", imem_addr, 32'h8);

        // two wait states
        @(negedge clk);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("ws_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        check("ws_pc", pc_out, 32'h4);

        // stall in the ack cycle, three cycles
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("st_req", {31'd0, imem_req}, 32'd0);
        check("st_pc", pc_out, 32'h4);
        step(0, 0, 0, 0);
        check("st_pc2", pc_out, 32'h8);
        check("st_in", instr_out, 32'h2009_0002);
        check("st_addr", imem_addr, 32'h8);

        // redirect while 0xC is outstanding
        step(0, 0, 0, 1);
        check("rd_pre", imem_addr, 32'hC);
        step(0, 1, 32'h42, 0);
        check("rd_vld", {31'd0, instr_valid}, 32'd0);
        check("rd_hold", imem_addr, 32'hC);
        step(0, 0, 0, 1);
        check("rd_addr", imem_addr, 32'h40);

        // redirect + stall while holding
        step(1, 0, 0, 1);
        step(1, 1, 32'h103, 0);
        check("rh_addr", imem_addr, 32'h100);

        // wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFE, 1);
        check("wr_a0", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wr_pc", pc_out, 32'h0);
        check("wr_a1", imem_addr, 32'h0);

        // reset during a wait
        step(0, 0, 0, 0);
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, r, a;
            logic [31:0] rpc;
            s = ($urandom_range(3) == 0);
            r = ($urandom_range(9) == 0);
            a = ($urandom_range(1) == 0);
            if ($urandom_range(3) == 0)
                rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                rpc = $urandom;
            if ($urandom_range(299) == 0)
                do_reset();
            else
                step(s, r, rpc, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
